char_console_ctrl: RTL and testbench

Sequences writes into the 16384 x 8 character RAM's write port (clka/wea/addra/dia) from a byte stream of ASCII characters and control codes. Maintains a text cursor over a COLS x ROWS grid and computes linear addresses as row*COLS+col. Handles line advance, wrap to the top with line clearing, and full-screen clear. The display scanner keeps sole use of the read port.

---
 rtl/char_console_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_char_console_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_console_ctrl.sv
// Character console write sequencer: turns an ASCII/control byte stream into character RAM writes.
// Optional TAB expansion (0x09 to next multiple of 8) is compiled in with `define CONSOLE_TAB_EN.
module char_console_ctrl #(
  parameter int unsigned COLS      = 100,
  parameter int unsigned ROWS      = 100,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        wea,
  output logic [13:0] addra,
  output logic [7:0]  dia,
  output logic [6:0]  cursor_col,
  output logic [6:0]  cursor_row,
  output logic        busy
);

  localparam logic [6:0]  ColLast  = 7'(COLS - 1);
  localparam logic [6:0]  RowLast  = 7'(ROWS - 1);
  localparam logic [13:0] RowStep  = 14'(COLS);
  localparam logic [13:0] LineLast = 14'(COLS - 1);
  localparam logic [13:0] AddrLast = 14'(COLS * ROWS - 1);

  localparam logic [7:0] ChBs  = 8'h08;
  localparam logic [7:0] ChTab = 8'h09;
  localparam logic [7:0] ChLf  = 8'h0a;
  localparam logic [7:0] ChFf  = 8'h0c;
  localparam logic [7:0] ChCr  = 8'h0d;

`ifdef CONSOLE_TAB_EN
  typedef enum logic [1:0] {StIdle, StClrLine, StClrAll, StTabFill} state_e;
`else
  typedef enum logic [1:0] {StIdle, StClrLine, StClrAll} state_e;
`endif

  state_e      state;
  logic [6:0]  col;
  logic [6:0]  row;
  logic [13:0] row_base;
  logic [13:0] clr_idx;

  logic        printable;
  logic        at_line_end;
  logic        wrap;
  logic        at_tab_stop;
  logic [6:0]  next_row;
  logic [13:0] next_base;
  logic [13:0] cur_addr;

  // row_base tracks row*COLS incrementally so no multiplier is needed.
  always_comb begin
    printable   = (s_data >= 8'h20) && (s_data <= 8'h7e);
    at_line_end = (col == ColLast);
    wrap        = (row == RowLast);
    at_tab_stop = (col[2:0] == 3'd7);
    next_row    = wrap ? 7'd0 : row + 7'd1;
    next_base   = wrap ? 14'd0 : row_base + RowStep;
    cur_addr    = row_base + {7'd0, col};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      col      <= 7'd0;
      row      <= 7'd0;
      row_base <= 14'd0;
      clr_idx  <= 14'd0;
      wea      <= 1'b0;
      addra    <= 14'd0;
      dia      <= FILL_CHAR;
    end else begin
      wea <= 1'b0;
      case (state)
        StIdle: begin
          if (s_valid) begin
            if (printable) begin
              wea   <= 1'b1;
              addra <= cur_addr;
              dia   <= s_data;
              if (at_line_end) begin
                col      <= 7'd0;
                row      <= next_row;
                row_base <= next_base;
                clr_idx  <= 14'd0;
                state    <= StClrLine;
              end else begin
                col <= col + 7'd1;
              end
            end else begin
              case (s_data)
                ChLf: begin
                  col      <= 7'd0;
                  row      <= next_row;
                  row_base <= next_base;
                  clr_idx  <= 14'd0;
                  state    <= StClrLine;
                end
                ChCr: col <= 7'd0;
                ChBs: begin
                  if (col != 7'd0) begin
                    col   <= col - 7'd1;
                    wea   <= 1'b1;
                    addra <= cur_addr - 14'd1;
                    dia   <= FILL_CHAR;
                  end
                end
                ChFf: begin
                  col      <= 7'd0;
                  row      <= 7'd0;
                  row_base <= 14'd0;
                  clr_idx  <= 14'd0;
                  state    <= StClrAll;
                end
`ifdef CONSOLE_TAB_EN
                // The first skipped cell is written on the accepting edge.
                ChTab: begin
                  wea   <= 1'b1;
                  addra <= cur_addr;
                  dia   <= FILL_CHAR;
                  if (at_line_end) begin
                    col      <= 7'd0;
                    row      <= next_row;
                    row_base <= next_base;
                    clr_idx  <= 14'd0;
                    state    <= StClrLine;
                  end else if (at_tab_stop) begin
                    col <= col + 7'd1;
                  end else begin
                    col   <= col + 7'd1;
                    state <= StTabFill;
                  end
                end
`endif
                default: ;
              endcase
            end
          end
        end

        StClrLine: begin
          wea   <= 1'b1;
          addra <= row_base + clr_idx;
          dia   <= FILL_CHAR;
          if (clr_idx == LineLast) begin
            state <= StIdle;
          end else begin
            clr_idx <= clr_idx + 14'd1;
          end
        end

        StClrAll: begin
          wea   <= 1'b1;
          addra <= clr_idx;
          dia   <= FILL_CHAR;
          if (clr_idx == AddrLast) begin
            state <= StIdle;
          end else begin
            clr_idx <= clr_idx + 14'd1;
          end
        end

`ifdef CONSOLE_TAB_EN
        StTabFill: begin
          wea   <= 1'b1;
          addra <= cur_addr;
          dia   <= FILL_CHAR;
          if (at_line_end) begin
            col      <= 7'd0;
            row      <= next_row;
            row_base <= next_base;
            clr_idx  <= 14'd0;
            state    <= StClrLine;
          end else if (at_tab_stop) begin
            col   <= col + 7'd1;
            state <= StIdle;
          end else begin
            col <= col + 7'd1;
          end
        end
`endif

        default: state <= StIdle;
      endcase
    end
  end

  assign s_ready    = (state == StIdle) && !rst;
  assign busy       = (state != StIdle);
  assign cursor_col = col;
  assign cursor_row = row;

endmodule

// File: tb/tb_char_console_ctrl.sv
// Directed and randomized bench for char_console_ctrl against a screen-level reference model.
module tb_char_console_ctrl;

  localparam int COLS = 100;
  localparam int ROWS = 100;
  localparam int CELLS = COLS * ROWS;
  localparam logic [7:0] FILL = 8'h20;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        wea;
  logic [13:0] addra;
  logic [7:0]  dia;
  logic [6:0]  cursor_col;
  logic [6:0]  cursor_row;
  logic        busy;

  char_console_ctrl #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .FILL_CHAR (FILL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .wea        (wea),
    .addra      (addra),
    .dia        (dia),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference screen: cursor as plain integers, cell index row*COLS+col.
  logic [7:0] m_mem [CELLS];
  logic [7:0] d_mem [CELLS];
  int m_col = 0;
  int m_row = 0;
  int m_writes = 0;
  int d_writes = 0;

  task automatic m_newline();
    m_row = (m_row + 1) % ROWS;
    for (int c = 0; c < COLS; c++) m_mem[m_row * COLS + c] = FILL;
    m_writes += COLS;
  endtask

  task automatic model_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7e) begin
      m_mem[m_row * COLS + m_col] = b;
      m_writes++;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_newline();
      end
    end else if (b == 8'h0a) begin
      m_col = 0;
      m_newline();
    end else if (b == 8'h0d) begin
      m_col = 0;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_mem[m_row * COLS + m_col] = FILL;
        m_writes++;
      end
    end else if (b == 8'h0c) begin
      m_col = 0;
      m_row = 0;
      for (int a = 0; a < CELLS; a++) m_mem[a] = FILL;
      m_writes += CELLS;
    end
`ifdef CONSOLE_TAB_EN
    else if (b == 8'h09) begin
      int tgt;
      tgt = (m_col / 8 + 1) * 8;
      if (tgt >= COLS) begin
        for (int c = m_col; c < COLS; c++) m_mem[m_row * COLS + c] = FILL;
        m_writes += COLS - m_col;
        m_col = 0;
        m_newline();
      end else begin
        for (int c = m_col; c < tgt; c++) m_mem[m_row * COLS + c] = FILL;
        m_writes += tgt - m_col;
        m_col = tgt;
      end
    end
`endif
  endtask

  // Captures every RAM write the DUT issues.
  always @(negedge clk) begin
    if (wea === 1'b1) begin
      d_writes++;
      d_mem[addra] = dia;
      chk("addr range", 32'(int'(addra) < CELLS), 32'd1);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (s_ready !== 1'b1 && n < 12000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready wait", 32'(s_ready), 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_idle();
    s_valid = 1'b1;
    s_data  = b;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = 8'($urandom);
    model_apply(b);
  endtask

  task automatic run_clear(input string tag, input int base, input int n);
    int cnt = 0;
    int bad = 0;
    while (busy === 1'b1 && cnt < n + 20) begin
      @(posedge clk); #1;
      cnt++;
      if (!(wea === 1'b1 && int'(addra) == base + cnt - 1 && dia === FILL)) bad++;
    end
    chk({tag, " busy cycles"}, 32'(cnt), 32'(n));
    chk({tag, " clear writes"}, 32'(bad), 32'd0);
  endtask

  task automatic checkpoint(input string tag);
    int bad = 0;
    wait_idle();
    @(posedge clk); #1;
    for (int a = 0; a < CELLS; a++) if (d_mem[a] !== m_mem[a]) bad++;
    chk({tag, " screen cells"}, 32'(bad), 32'd0);
    chk({tag, " write count"}, 32'(d_writes), 32'(m_writes));
    chk({tag, " col"}, 32'(cursor_col), 32'(m_col));
    chk({tag, " row"}, 32'(cursor_row), 32'(m_row));
  endtask

  initial begin
    logic [7:0] b;
    int r;
    int ff_budget = 2;

    for (int a = 0; a < CELLS; a++) begin
      m_mem[a] = 8'h00;
      d_mem[a] = 8'h00;
    end
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("ready in reset", 32'(s_ready), 32'd0);
    chk("reset wea", 32'(wea), 32'd0);
    chk("reset addra", 32'(addra), 32'd0);
    chk("reset dia", 32'(dia), 32'(FILL));
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset col", 32'(cursor_col), 32'd0);
    chk("reset row", 32'(cursor_row), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready after reset", 32'(s_ready), 32'd1);

    // "AB" back to back
    s_valid = 1'b1;
    s_data = 8'h41;
    @(posedge clk); #1;
    chk("A wea", 32'(wea), 32'd1);
    chk("A addr", 32'(addra), 32'd0);
    chk("A data", 32'(dia), 32'h41);
    chk("A ready", 32'(s_ready), 32'd1);
    s_data = 8'h42;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("B wea", 32'(wea), 32'd1);
    chk("B addr", 32'(addra), 32'd1);
    chk("B data", 32'(dia), 32'h42);
    chk("B col", 32'(cursor_col), 32'd2);
    model_apply(8'h41);
    model_apply(8'h42);
    @(posedge clk); #1;
    chk("idle wea low", 32'(wea), 32'd0);

    // Last column write then line clear of row 1
    for (int i = 0; i < 97; i++) send(8'h78);
    chk("pre-Z col", 32'(cursor_col), 32'd99);
    s_valid = 1'b1;
    s_data = 8'h5a;
    @(posedge clk); #1;
    s_valid = 1'b0;
    model_apply(8'h5a);
    chk("Z wea", 32'(wea), 32'd1);
    chk("Z addr", 32'(addra), 32'd99);
    chk("Z data", 32'(dia), 32'h5a);
    chk("Z ready low", 32'(s_ready), 32'd0);
    run_clear("row1", 100, 100);
    chk("after Z col", 32'(cursor_col), 32'd0);
    chk("after Z row", 32'(cursor_row), 32'd1);
    chk("after Z ready", 32'(s_ready), 32'd1);
    checkpoint("cp1");

    // LF on the last row wraps to row 0
    for (int i = 0; i < 98; i++) send(8'h0a);
    for (int i = 0; i < 5; i++) send(8'h71);
    wait_idle();
    chk("pre-LF col", 32'(cursor_col), 32'd5);
    chk("pre-LF row", 32'(cursor_row), 32'd99);
    s_valid = 1'b1;
    s_data = 8'h0a;
    @(posedge clk); #1;
    s_valid = 1'b0;
    model_apply(8'h0a);
    chk("LF no char write", 32'(wea), 32'd0);
    chk("LF busy", 32'(busy), 32'd1);
    run_clear("wrap", 0, 100);
    chk("wrap col", 32'(cursor_col), 32'd0);
    chk("wrap row", 32'(cursor_row), 32'd0);
    checkpoint("cp2");

    // FF aborted by reset after 50 clear writes
    send(8'h68);
    send(8'h69);
    wait_idle();
    s_valid = 1'b1;
    s_data = 8'h0c;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("FF wea", 32'(wea), 32'd0);
    chk("FF busy", 32'(busy), 32'd1);
    chk("FF col", 32'(cursor_col), 32'd0);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      chk("FF clear addr", 32'(addra), 32'(k));
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort wea", 32'(wea), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    for (int a = 0; a < 50; a++) m_mem[a] = FILL;
    m_writes += 50;
    m_col = 0;
    m_row = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("post-abort wea", 32'(wea), 32'd0);
    checkpoint("cp3");

    // BS, CR, BS at column 0
    send(8'h61);
    send(8'h62);
    send(8'h63);
    wait_idle();
    s_valid = 1'b1;
    s_data = 8'h08;
    @(posedge clk); #1;
    model_apply(8'h08);
    chk("BS wea", 32'(wea), 32'd1);
    chk("BS addr", 32'(addra), 32'd2);
    chk("BS data", 32'(dia), 32'(FILL));
    chk("BS col", 32'(cursor_col), 32'd2);
    s_data = 8'h0d;
    @(posedge clk); #1;
    model_apply(8'h0d);
    chk("CR wea", 32'(wea), 32'd0);
    chk("CR col", 32'(cursor_col), 32'd0);
    s_data = 8'h08;
    @(posedge clk); #1;
    s_valid = 1'b0;
    model_apply(8'h08);
    chk("BS0 wea", 32'(wea), 32'd0);
    chk("BS0 col", 32'(cursor_col), 32'd0);

    // TAB from column 3
    send(8'h78);
    send(8'h79);
    send(8'h7a);
    wait_idle();
    s_valid = 1'b1;
    s_data = 8'h09;
    @(posedge clk); #1;
    s_valid = 1'b0;
    model_apply(8'h09);
`ifdef CONSOLE_TAB_EN
    begin
      int bad = 0;
      for (int k = 0; k < 5; k++) begin
        if (k > 0) begin
          @(posedge clk); #1;
        end
        if (!(wea === 1'b1 && int'(addra) == 3 + k && dia === FILL)) bad++;
      end
      chk("TAB fill writes", 32'(bad), 32'd0);
      chk("TAB col", 32'(cursor_col), 32'd8);
      @(posedge clk); #1;
      chk("TAB done wea", 32'(wea), 32'd0);
    end
`else
    chk("TAB ignored wea", 32'(wea), 32'd0);
    chk("TAB ignored col", 32'(cursor_col), 32'd3);
    chk("TAB ignored ready", 32'(s_ready), 32'd1);
`endif
    checkpoint("cp4");

    // Randomized byte stream
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 700) b = 8'($urandom_range(32, 126));
      else if (r < 780) b = 8'h0a;
      else if (r < 830) b = 8'h0d;
      else if (r < 900) b = 8'h08;
      else if (r < 950) b = 8'h09;
      else if (r < 997) b = r[0] ? 8'h1b : 8'($urandom_range(127, 255));
      else if (ff_budget > 0) begin
        b = 8'h0c;
        ff_budget--;
      end else b = 8'h2e;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(b);
      if (i % 250 == 249) checkpoint("rand");
    end
    checkpoint("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
